// File: rtl/uart_tx_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered 8N1 UART transmitter. Bytes are queued in a circular
//               FIFO and serialised back-to-back onto com_TxD.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int AW       = 4
) (
    input  logic          clk50M,
    input  logic          rst_key,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_ovf,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   fifo_count,
    output logic          tx_busy,
    output logic          overflow,
    output logic          com_TxD
);

    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int DEPTH = 2 ** AW;
    localparam int BW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] c_baud_last = BW'(DIV - 1);
    localparam logic [AW:0]   c_depth     = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t          r_state_q,  w_state_d;
    logic [BW-1:0]   r_baud_q,   w_baud_d;
    logic [2:0]      r_bit_q,    w_bit_d;
    logic [7:0]      r_shift_q,  w_shift_d;
    logic            r_txd_q,    w_txd_d;
    logic            r_busy_q,   w_busy_d;
    logic [AW-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [AW-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [AW:0]     r_count_q,  w_count_d;
    logic            r_full_q,   w_full_d;
    logic            r_empty_q,  w_empty_d;
    logic            r_ovf_q,    w_ovf_d;

    logic [7:0]      r_mem_q [DEPTH];
    logic            w_push;
    logic            w_pop;
    logic            w_baud_done;

    // Storage carries no reset: stale entries are never read while count is 0.
    always_ff @(posedge clk50M) begin
        if (w_push) begin
            r_mem_q[r_wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        w_push      = wr_en && !r_full_q;
        w_pop       = 1'b0;
        w_baud_done = (r_baud_q == c_baud_last);
        w_state_d   = r_state_q;
        w_baud_d    = r_baud_q;
        w_bit_d     = r_bit_q;
        w_shift_d   = r_shift_q;
        w_txd_d     = r_txd_q;

        unique case (r_state_q)
            ST_IDLE: begin
                w_txd_d = 1'b1;
                if (!r_empty_q) begin
                    w_pop     = 1'b1;
                    w_shift_d = r_mem_q[r_rd_ptr_q];
                    w_state_d = ST_START;
                    w_txd_d   = 1'b0;
                    w_baud_d  = '0;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_state_d = ST_DATA;
                    w_txd_d   = r_shift_q[0];
                    w_baud_d  = '0;
                    w_bit_d   = 3'd0;
                end else begin
                    w_baud_d = r_baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_d = '0;
                    if (r_bit_q == 3'd7) begin
                        w_state_d = ST_STOP;
                        w_txd_d   = 1'b1;
                    end else begin
                        w_bit_d   = r_bit_q + 3'd1;
                        w_shift_d = {1'b0, r_shift_q[7:1]};
                        w_txd_d   = r_shift_q[1];
                    end
                end else begin
                    w_baud_d = r_baud_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_d = '0;
                    // Chain straight into the next start bit so frames abut.
                    if (!r_empty_q) begin
                        w_pop     = 1'b1;
                        w_shift_d = r_mem_q[r_rd_ptr_q];
                        w_state_d = ST_START;
                        w_txd_d   = 1'b0;
                    end else begin
                        w_state_d = ST_IDLE;
                        w_txd_d   = 1'b1;
                    end
                end else begin
                    w_baud_d = r_baud_q + BW'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_txd_d   = 1'b1;
            end
        endcase

        w_busy_d   = (w_state_d != ST_IDLE);
        w_rd_ptr_d = w_pop  ? r_rd_ptr_q + AW'(1) : r_rd_ptr_q;
        w_wr_ptr_d = w_push ? r_wr_ptr_q + AW'(1) : r_wr_ptr_q;

        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + (AW + 1)'(1);
            2'b01:   w_count_d = r_count_q - (AW + 1)'(1);
            default: w_count_d = r_count_q;
        endcase
        w_full_d  = (w_count_d == c_depth);
        w_empty_d = (w_count_d == '0);

        // A rejected push in the same cycle as a clear keeps the flag set.
        if (wr_en && r_full_q) begin
            w_ovf_d = 1'b1;
        end else if (clr_ovf) begin
            w_ovf_d = 1'b0;
        end else begin
            w_ovf_d = r_ovf_q;
        end
    end

    always_ff @(posedge clk50M or negedge rst_key) begin
        if (!rst_key) begin
            r_state_q  <= ST_IDLE;
            r_baud_q   <= '0;
            r_bit_q    <= 3'd0;
            r_shift_q  <= 8'd0;
            r_txd_q    <= 1'b1;
            r_busy_q   <= 1'b0;
            r_rd_ptr_q <= '0;
            r_wr_ptr_q <= '0;
            r_count_q  <= '0;
            r_full_q   <= 1'b0;
            r_empty_q  <= 1'b1;
            r_ovf_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_baud_q   <= w_baud_d;
            r_bit_q    <= w_bit_d;
            r_shift_q  <= w_shift_d;
            r_txd_q    <= w_txd_d;
            r_busy_q   <= w_busy_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_count_q  <= w_count_d;
            r_full_q   <= w_full_d;
            r_empty_q  <= w_empty_d;
            r_ovf_q    <= w_ovf_d;
        end
    end

    assign full       = r_full_q;
    assign empty      = r_empty_q;
    assign fifo_count = r_count_q;
    assign tx_busy    = r_busy_q;
    assign overflow   = r_ovf_q;
    assign com_TxD    = r_txd_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Randomised bench for uart_tx_fifo against a frame-level model
//               plus an independent line decoder (DIV = 10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int c_div   = 10;
    localparam int c_depth = 16;

    logic       clk50M = 1'b0;
    logic       rst_key = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       clr_ovf = 1'b0;
    logic       full, empty, tx_busy, overflow, com_TxD;
    logic [4:0] fifo_count;

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .AW(4)) dut (
        .clk50M     (clk50M),
        .rst_key    (rst_key),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr_ovf    (clr_ovf),
        .full       (full),
        .empty      (empty),
        .fifo_count (fifo_count),
        .tx_busy    (tx_busy),
        .overflow   (overflow),
        .com_TxD    (com_TxD)
    );

    always #5 clk50M = ~clk50M;

    int n_total = 0;
    int n_bad   = 0;

    // Frame-level model: queue contents, which byte is on the wire and when
    // its start edge happened.
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    logic [7:0] m_cur = 8'd0;
    bit         m_active = 1'b0;
    bit         m_ovf = 1'b0;
    int         m_n = 0;
    int         m_fs = 0;
    int         m_gen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_line();
        int k;
        int idx;
        if (!m_active) return 1'b1;
        k   = m_n - m_fs;
        idx = k / c_div;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_cur[idx-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_sent.delete();
        m_active = 1'b0;
        m_ovf    = 1'b0;
        m_gen++;
    endtask

    task automatic check_outputs();
        check_eq("txd",   com_TxD,    exp_line());
        check_eq("count", fifo_count, m_q.size());
        check_eq("full",  full,       m_q.size() == c_depth);
        check_eq("empty", empty,      m_q.size() == 0);
        check_eq("busy",  tx_busy,    m_active);
        check_eq("ovf",   overflow,   m_ovf);
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic c);
        int cnt;
        wr_en   = w;
        wr_data = d;
        clr_ovf = c;
        @(posedge clk50M);
        m_n++;
        cnt = m_q.size();
        if (cnt != 0 && (!m_active || m_n == m_fs + 10 * c_div)) begin
            m_cur    = m_q.pop_front();
            m_sent.push_back(m_cur);
            m_fs     = m_n;
            m_active = 1'b1;
        end else if (m_active && m_n == m_fs + 10 * c_div) begin
            m_active = 1'b0;
        end
        if (w && cnt < c_depth) m_q.push_back(d);
        if (w && cnt == c_depth) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        #1;
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 8'd0, 1'b0);
    endtask

    task automatic drain();
        int budget = 4000;
        while ((m_active || m_q.size() != 0) && budget > 0) begin
            step(1'b0, 8'd0, 1'b0);
            budget--;
        end
        idle(5);
    endtask

    // Independent decoder: samples each bit near its middle on falling clocks.
    initial begin
        logic [9:0] bits;
        int         gen0;
        forever begin
            @(negedge clk50M);
            if (rst_key && com_TxD == 1'b0) begin
                gen0 = m_gen;
                for (int i = 0; i < 10; i++) begin
                    repeat ((i == 0) ? 4 : c_div) @(negedge clk50M);
                    bits[i] = com_TxD;
                end
                if (gen0 == m_gen && rst_key) begin
                    check_eq("rx_start", bits[0], 1'b0);
                    check_eq("rx_stop",  bits[9], 1'b1);
                    check_eq("rx_expected", m_sent.size() != 0, 1'b1);
                    if (m_sent.size() != 0) check_eq("rx_byte", bits[8:1], m_sent.pop_front());
                end
            end
        end
    end

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk50M);
        #1;
        check_outputs();
        @(negedge clk50M);
        rst_key = 1'b1;

        // Single byte
        step(1'b1, 8'hA5, 1'b0);
        idle(110);

        // Back-to-back frames
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        drain();

        // Overflow while a frame is on the wire, then set-over-clear
        step(1'b1, 8'h5A, 1'b0);
        idle(20);
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        drain();

        // Random traffic
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
        drain();

        // Reset in the middle of data bit 3
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        idle(45);
        #2;
        rst_key = 1'b0;
        model_reset();
        #1;
        check_eq("async_txd",   com_TxD, 1'b1);
        check_eq("async_empty", empty,   1'b1);
        check_eq("async_busy",  tx_busy, 1'b0);
        repeat (3) @(posedge clk50M);
        #1;
        check_outputs();
        @(negedge clk50M);
        rst_key = 1'b1;
        idle(150);

        // Pointer wrap: 40 sequential bytes
        for (int v = 0; v < 40; v++) begin
            while (m_q.size() >= c_depth) step(1'b0, 8'd0, 1'b0);
            step(1'b1, 8'(v), 1'b0);
        end
        drain();
        check_eq("final_count", fifo_count, 0);
        check_eq("rx_left", m_sent.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter driving `com_TxD`, the outbound counterpart of the serial receiver on `com_RxD`. The CPU's memory-mapped serial port pushes bytes into a small FIFO. A baud-rate state machine then serialises them onto the line, back-to-back with no idle gap. It sits between the CPU bus decoder and the `com_TxD` top-level pin, in the `clk50M` domain.

## Interface
- `CLK_FREQ`, 50000000, input clock frequency in Hz.
- `BAUD`, 115200, line rate. `DIV = (CLK_FREQ + BAUD/2) / BAUD` is clock cycles per bit; the default gives 434. `DIV` ≥ 2.
- `AW`, 4, FIFO address width; depth is `2**AW` = 16.
- `clk50M` in 1: sole clock, rising edge.
- `rst_key` in 1: reset. Asynchronous, active-low.
- `wr_en` in 1: push request, sampled on the rising edge.
- `wr_data` in 8: byte to push.
- `clr_ovf` in 1: clears `overflow`.
- `full` out 1: FIFO holds `2**AW` bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `fifo_count` out AW+1: bytes currently queued, excluding the byte on the wire.
- `tx_busy` out 1: FSM not in IDLE.
- `overflow` out 1: sticky flag; a push was dropped.
- `com_TxD` out 1: serial line, idle high, registered.

## Operation
- **FIFO:** circular buffer with AW-bit read and write pointers plus an AW+1-bit count. Pointers wrap modulo `2**AW`.
- **Push:** accepted iff `wr_en` and `full`==0, using the pre-edge value of `full`. A concurrent pop does not make room in the same cycle.
- **Rejected push:** `wr_en` while `full` leaves the FIFO unchanged and sets `overflow`. Writes are never silently merged.
- **`overflow`:** cleared by `clr_ovf`. If `clr_ovf` and a rejected push occur in the same cycle, set wins.
- **Pop:** occurs when the FSM takes a byte, only if `fifo_count`≠0 before the edge. There is no bypass from `wr_data` to the shifter.
- **Simultaneous push and pop:** count unchanged; both pointers advance.
- **FSM states:** IDLE, START, DATA, STOP. A bit counter (0..7) and a baud counter (0..DIV-1) run alongside.
  - IDLE: `com_TxD`=1. If !empty: pop into an 8-bit shift register, go to START, drive `com_TxD`=0, clear the baud counter.
  - START: hold 0 for DIV cycles, then go to DATA with `com_TxD`=shift[0].
  - DATA: each bit is held DIV cycles, LSB first. After bit 7, go to STOP with `com_TxD`=1.
  - STOP: hold 1 for DIV cycles. At the end, if !empty, pop and go directly to START (`com_TxD`=0 on that edge); else go to IDLE.
- **Frame length:** exactly 10·DIV cycles from the start-bit falling edge to the next possible start-bit falling edge.
- **Reset (asynchronous, any time including mid-frame):** `com_TxD`=1, FSM=IDLE, pointers=0, `fifo_count`=0, `empty`=1, `full`=0, `tx_busy`=0, `overflow`=0. The partial frame is abandoned and queued bytes are discarded.

## Timing
- **Push to wire:** push on edge E0 → `fifo_count`=1 and `empty`=0 after E0. On E1 the FSM pops and `com_TxD` falls, so the line falls 1 cycle after the push edge when idle.
- **`tx_busy`:** high from E1 until the edge that returns the FSM to IDLE.
- **Status outputs:** `full`, `empty` and `fifo_count` are registered and reflect the state after each edge.
- **Throughput:** sustained at 1 byte per 10·DIV cycles. The FIFO absorbs bursts of up to 16 bytes plus 1 in the shifter.

## Test plan
Run with `CLK_FREQ`=1000, `BAUD`=100, giving DIV=10.
- **Single byte:** reset, then push 0xA5 → line falls 1 cycle later. Line samples at the mid-point of each bit are 0,1,0,1,0,0,1,0,1,1. `tx_busy` drops 100 cycles after the fall.
- **Back-to-back:** push 0x00, 0xFF on consecutive cycles → second start bit falls exactly 100 cycles after the first, with no idle high between the stop bit and that start bit. `fifo_count` sequence is 1, 1 (simultaneous pop and push), then 0.
- **Overflow:** with the FSM mid-frame, push 17 bytes → `full`=1 after the 16th push. The 17th push is dropped and `overflow`=1. Assert `clr_ovf` → `overflow`=0. The 16 queued bytes transmit in order.
- **Set-over-clear:** `clr_ovf` and a rejected push in the same cycle → `overflow` stays 1.
- **Reset mid-frame:** assert `rst_key`=0 during DATA bit 3 → `com_TxD`=1 immediately without waiting for a clock, and `empty`=1. After release, no residual frame appears.
- **Pointer wrap:** push and drain 40 bytes in total, values 0x00..0x27 → all received in order and `fifo_count` returns to 0.
